// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp_pkg
// Purpose  : Shared defaults for the multi-port register file. Compile-time
//            switch REGFILE_ZERO_REG_EN hardwires register 0 to zero.
// Revision : 1.0
// ============================================================================
package reg_file_mp_pkg;

    localparam int C_DEF_DATA_W   = 16;
    localparam int C_DEF_ADDR_W   = 3;
    localparam int C_DEF_RD_PORTS = 2;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit C_ZERO_REG_EN = 1'b1;
`else
    localparam bit C_ZERO_REG_EN = 1'b0;
`endif

    // A write or reserve aimed at a hardwired-zero register has no effect.
    function automatic logic strobe_ok(input logic en, input logic is_zero_addr);
        return en && !(C_ZERO_REG_EN && is_zero_addr);
    endfunction

endpackage : reg_file_mp_pkg
`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_rd_port
// Purpose  : One read port: address mux, write bypass, post-edge busy lookup
//            and registered outputs.
// Revision : 1.0
// ============================================================================
module reg_file_rd_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rsv_en,
    input  logic [ADDR_W-1:0]       rsv_addr,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic [DEPTH-1:0]        busy,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_busy
);

    logic              w_bypass;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_bypass = wr_en && (wr_addr == rd_addr);

    // Strobes arrive already qualified, so the busy result mirrors the
    // scoreboard update: reserve beats write-clear.
    always_comb begin
        w_data = mem_flat[rd_addr*DATA_W +: DATA_W];
        w_busy = busy[rd_addr];
        if (w_bypass) begin
            w_data = wr_data;
            w_busy = 1'b0;
        end
        if (rsv_en && (rsv_addr == rd_addr)) begin
            w_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= w_data;
            rd_busy <= w_busy;
        end
    end

endmodule : reg_file_rd_port
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Register file with one write port, RD_PORTS bypassed read ports
//            and a busy scoreboard. Optional macro: REGFILE_ZERO_REG_EN.
// Revision : 1.0
// ============================================================================
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = C_DEF_DATA_W,
    parameter int ADDR_W   = C_DEF_ADDR_W,
    parameter int RD_PORTS = C_DEF_RD_PORTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    output logic [RD_PORTS-1:0]        rd_busy,
    output logic [2**ADDR_W-1:0]       busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DEPTH-1:0]        r_busy;
    logic [DEPTH*DATA_W-1:0] w_mem_flat;
    logic                    w_wr_en;
    logic                    w_rsv_en;

    assign w_wr_en  = strobe_ok(wr_en,  wr_addr  == '0);
    assign w_rsv_en = strobe_ok(rsv_en, rsv_addr == '0);

    // Reserve is applied after the write so a same-address collision ends busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[wr_addr]  <= wr_data;
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_rsv_en) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign w_mem_flat[i*DATA_W +: DATA_W] = r_mem[i];
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
            .wr_en    (w_wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rsv_en   (w_rsv_en),
            .rsv_addr (rsv_addr),
            .mem_flat (w_mem_flat),
            .busy     (r_busy),
            .rd_data  (rd_data[p*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Directed self-checking bench for reg_file_mp (default sizes).
// Revision : 1.0
// ============================================================================
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic [7:0]  busy_vec;

    int errors = 0;
    int checks = 0;

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .RD_PORTS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
        rd_en  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_busy_vec", {24'h0, busy_vec}, 32'h0);
        rst = 1'b1;

        // Reset then read every address on both ports
        for (int a = 0; a < 8; a++) begin
            rd_en   = 1'b1;
            rd_addr = {3'(7 - a), 3'(a)};
            step();
            chk($sformatf("post_reset_data_r%0d", a), rd_data, 32'h0);
            chk($sformatf("post_reset_busy_r%0d", a), {30'h0, rd_busy}, 32'h0);
        end
        chk("post_reset_busy_vec", {24'h0, busy_vec}, 32'h0);

        // Write then read on the following edge
        idle();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        step();
        idle();
        rd_en = 1'b1; rd_addr = {3'd5, 3'd3};
        step();
        chk("wr_rd_port0", {16'h0, rd_data[15:0]}, 32'hBEEF);
        chk("wr_rd_port1", {16'h0, rd_data[31:16]}, 32'h0);

        // Same-edge bypass, both ports on one address
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        rd_en = 1'b1; rd_addr = {3'd2, 3'd2};
        step();
        idle();
        chk("bypass_both", rd_data, 32'h1234_1234);

        // Scoreboard
        rsv_en = 1'b1; rsv_addr = 3'd4;
        step();
        idle();
        chk("rsv_busy_vec", {24'h0, busy_vec}, 32'h10);
        rd_en = 1'b1; rd_addr = {3'd3, 3'd4};
        step();
        idle();
        chk("rd_busy_r4", {30'h0, rd_busy}, 32'h1);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00AA;
        step();
        idle();
        chk("wr_clears_busy", {24'h0, busy_vec}, 32'h0);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00AA;
        rsv_en = 1'b1; rsv_addr = 3'd4;
        step();
        idle();
        chk("rsv_wins_busy", {24'h0, busy_vec}, 32'h10);
        rd_en = 1'b1; rd_addr = {3'd4, 3'd4};
        step();
        idle();
        chk("rsv_wr_data", rd_data, 32'h00AA_00AA);
        chk("rsv_wr_rd_busy", {30'h0, rd_busy}, 32'h3);

        // Reserve+write on r6 with a bypassed read at the same edge
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A;
        rsv_en = 1'b1; rsv_addr = 3'd6;
        rd_en = 1'b1; rd_addr = {3'd2, 3'd6};
        step();
        idle();
        chk("byp_rsv_data", rd_data, 32'h1234_5A5A);
        chk("byp_rsv_busy", {30'h0, rd_busy}, 32'h1);
        chk("byp_rsv_busy_vec", {24'h0, busy_vec}, 32'h50);

        // Write-only on the read address: post-edge busy is cleared
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0F0F;
        rd_en = 1'b1; rd_addr = {3'd4, 3'd6};
        step();
        idle();
        chk("byp_clr_data", rd_data, 32'h00AA_0F0F);
        chk("byp_clr_busy", {30'h0, rd_busy}, 32'h2);

        // Hold when rd_en is low
        rd_en = 1'b1; rd_addr = {3'd2, 3'd3};
        step();
        chk("hold_setup", rd_data, 32'h1234_BEEF);
        rd_en = 1'b0; rd_addr = {3'd5, 3'd4};
        step();
        step();
        chk("hold_data", rd_data, 32'h1234_BEEF);
        chk("hold_busy", {30'h0, rd_busy}, 32'h0);

        // Asynchronous reset between edges
        rd_en = 1'b1; rd_addr = {3'd4, 3'd4};
        step();
        idle();
        chk("pre_rst_data", rd_data, 32'h00AA_00AA);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_data", rd_data, 32'h0);
        chk("async_rst_busy", {30'h0, rd_busy}, 32'h0);
        chk("async_rst_busy_vec", {24'h0, busy_vec}, 32'h0);
        step();
        rst = 1'b1;
        rd_en = 1'b1; rd_addr = {3'd2, 3'd3};
        step();
        idle();
        chk("after_rst_mem", rd_data, 32'h0);

        // Register 0 behaviour
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        step();
        idle();
        rsv_en = 1'b1; rsv_addr = 3'd0;
        step();
        idle();
        rd_en = 1'b1; rd_addr = {3'd0, 3'd0};
        step();
        idle();
`ifdef REGFILE_ZERO_REG_EN
        chk("r0_data", rd_data, 32'h0);
        chk("r0_busy_vec", {24'h0, busy_vec}, 32'h0);
`else
        chk("r0_data", rd_data, 32'hFFFF_FFFF);
        chk("r0_busy_vec", {24'h0, busy_vec}, 32'h1);
`endif
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1111;
        rd_en = 1'b1; rd_addr = {3'd0, 3'd0};
        step();
        idle();
`ifdef REGFILE_ZERO_REG_EN
        chk("r0_bypass", rd_data, 32'h0);
`else
        chk("r0_bypass", rd_data, 32'h1111_1111);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_mp
`default_nettype wire
